// File: rtl/decode_regfile.sv
// decode_regfile: Y86-64 decode stage with 15-entry register file, writeback bypass and halt/error status
module decode_regfile #(
  parameter int NREG = 15,
  parameter logic [3:0] RSP_ID = 4'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  output logic        f_ready,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        w_enE,
  input  logic        w_enM,
  input  logic [3:0]  w_dstE,
  input  logic [3:0]  w_dstM,
  input  logic [63:0] w_valE,
  input  logic [63:0] w_valM,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB,
  output logic [63:0] d_valC,
  output logic [63:0] d_valP,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_dstE,
  output logic [3:0]  d_dstM,
  output logic [2:0]  stat
);
  localparam logic [3:0] NONE = 4'hF;
  typedef enum logic [1:0] {RUN, HALT, ERR} state_t;
  state_t state;
  logic [63:0] regs [NREG];
  logic [3:0] src_a, src_b, dst_e, dst_m;
  logic [63:0] val_a, val_b;
  logic accept;
  // M has priority over E in both the bypass and the array write
  always_comb begin
    src_a = (f_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? f_rA : (f_icode inside {4'h9, 4'hB}) ? RSP_ID : NONE;
    src_b = (f_icode inside {4'h4, 4'h5, 4'h6}) ? f_rB : (f_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP_ID : NONE;
    dst_e = (f_icode inside {4'h2, 4'h3, 4'h6}) ? f_rB : (f_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP_ID : NONE;
    dst_m = (f_icode inside {4'h5, 4'hB}) ? f_rA : NONE;
    val_a = (src_a == NONE) ? '0 : (w_enM && w_dstM == src_a) ? w_valM : (w_enE && w_dstE == src_a) ? w_valE : regs[src_a];
    val_b = (src_b == NONE) ? '0 : (w_enM && w_dstM == src_b) ? w_valM : (w_enE && w_dstE == src_b) ? w_valE : regs[src_b];
    f_ready = (state == RUN) && (!d_valid || d_ready);
    accept = f_valid && f_ready;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else begin
      if (w_enE && int'(w_dstE) < NREG) regs[w_dstE] <= w_valE;
      if (w_enM && int'(w_dstM) < NREG) regs[w_dstM] <= w_valM;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      stat <= 3'd1;
      d_valid <= 1'b0;
      d_icode <= '0;
      d_ifun <= '0;
      d_valA <= '0;
      d_valB <= '0;
      d_valC <= '0;
      d_valP <= '0;
      d_srcA <= NONE;
      d_srcB <= NONE;
      d_dstE <= NONE;
      d_dstM <= NONE;
    end else if (accept) begin
      state <= (f_icode == 4'h0) ? HALT : (f_icode > 4'hB) ? ERR : RUN;
      stat <= (f_icode == 4'h0) ? 3'd2 : (f_icode > 4'hB) ? 3'd4 : 3'd1;
      d_valid <= 1'b1;
      d_icode <= f_icode;
      d_ifun <= f_ifun;
      d_valA <= val_a;
      d_valB <= val_b;
      d_valC <= f_valC;
      d_valP <= f_valP;
      d_srcA <= src_a;
      d_srcB <= src_b;
      d_dstE <= dst_e;
      d_dstM <= dst_m;
    end else if (d_ready) begin
      d_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: directed stimulus checked against a per-cycle behavioural model plus literal expectations
module tb_decode_regfile;
  logic clk = 0, rst_n = 0;
  logic f_valid = 0, f_ready;
  logic [3:0] f_icode = 0, f_ifun = 0, f_rA = 4'hF, f_rB = 4'hF;
  logic [63:0] f_valC = 0, f_valP = 0;
  logic w_enE = 0, w_enM = 0;
  logic [3:0] w_dstE = 0, w_dstM = 0;
  logic [63:0] w_valE = 0, w_valM = 0;
  logic d_valid, d_ready = 1;
  logic [3:0] d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valA, d_valB, d_valC, d_valP;
  logic [2:0] stat;
  int checks = 0, errors = 0;

  decode_regfile dut (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_ready(f_ready),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .w_enE(w_enE), .w_enM(w_enM),
    .w_dstE(w_dstE), .w_dstM(w_dstM), .w_valE(w_valE), .w_valM(w_valM),
    .d_valid(d_valid), .d_ready(d_ready), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC), .d_valP(d_valP),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM), .stat(stat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [279:0] act, input logic [279:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: register file after this edge's writes equals what a bypassed read must return
  logic [63:0] m_regs [15];
  logic m_valid = 0, m_run = 1, started = 0;
  logic [2:0] m_stat = 1;
  logic [279:0] m_b = {8'h0, 256'h0, 16'hFFFF};

  function automatic logic [15:0] dec(input logic [3:0] ic, ra, rb);
    case (ic)
      4'h2: return {ra, 4'hF, rb, 4'hF};
      4'h3: return {4'hF, 4'hF, rb, 4'hF};
      4'h4: return {ra, rb, 4'hF, 4'hF};
      4'h5: return {4'hF, rb, 4'hF, ra};
      4'h6: return {ra, rb, rb, 4'hF};
      4'h8: return {4'hF, 4'd4, 4'd4, 4'hF};
      4'h9: return {4'd4, 4'd4, 4'd4, 4'hF};
      4'hA: return {ra, 4'd4, 4'd4, 4'hF};
      4'hB: return {4'd4, 4'd4, 4'd4, ra};
      default: return 16'hFFFF;
    endcase
  endfunction

  always @(posedge clk) begin : model
    logic [63:0] nr [15];
    logic [15:0] ids;
    if (!rst_n) begin
      started = 1;
      m_regs = '{default: 64'h0};
      m_valid = 0;
      m_run = 1;
      m_stat = 1;
      m_b = {8'h0, 256'h0, 16'hFFFF};
    end else begin
      nr = m_regs;
      if (w_enE && w_dstE != 4'hF) nr[w_dstE] = w_valE;
      if (w_enM && w_dstM != 4'hF) nr[w_dstM] = w_valM;
      if (f_valid && m_run && (!m_valid || d_ready)) begin
        ids = dec(f_icode, f_rA, f_rB);
        m_b = {f_icode, f_ifun,
               (ids[15:12] == 4'hF) ? 64'h0 : nr[ids[15:12]],
               (ids[11:8] == 4'hF) ? 64'h0 : nr[ids[11:8]],
               f_valC, f_valP, ids};
        m_valid = 1;
        if (f_icode == 4'h0) begin m_run = 0; m_stat = 2; end
        else if (f_icode > 4'hB) begin m_run = 0; m_stat = 4; end
      end else if (d_ready) m_valid = 0;
      m_regs = nr;
    end
  end

  always @(negedge clk) if (started) begin
    chk("f_ready", 280'(f_ready), 280'(m_run && (!m_valid || d_ready)));
    chk("d_valid", 280'(d_valid), 280'(m_valid));
    chk("stat", 280'(stat), 280'(m_stat));
    chk("bundle", {d_icode, d_ifun, d_valA, d_valB, d_valC, d_valP, d_srcA, d_srcB, d_dstE, d_dstM}, m_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [3:0] ic, ifn, ra, rb, input logic [63:0] c, p);
    f_valid = v; f_icode = ic; f_ifun = ifn; f_rA = ra; f_rB = rb; f_valC = c; f_valP = p;
  endtask

  initial begin
    step(); step();
    chk("rst d_valid", 280'(d_valid), 280'(0));
    chk("rst stat", 280'(stat), 280'(1));
    chk("rst f_ready", 280'(f_ready), 280'(1));
    chk("rst d_srcA", 280'(d_srcA), 280'(4'hF));
    chk("rst d_dstM", 280'(d_dstM), 280'(4'hF));
    chk("rst d_valA", 280'(d_valA), 280'(0));
    rst_n = 1;
    w_enE = 1; w_dstE = 3; w_valE = 64'h1122;
    step();
    w_enE = 0;
    fetch(1, 4'h6, 4'h0, 4'd3, 4'd3, 64'h0, 64'h10);
    step();
    chk("opq d_valA", 280'(d_valA), 280'(64'h1122));
    chk("opq d_valB", 280'(d_valB), 280'(64'h1122));
    chk("opq d_dstE", 280'(d_dstE), 280'(4'd3));
    chk("opq d_dstM", 280'(d_dstM), 280'(4'hF));
    fetch(1, 4'h4, 4'h0, 4'd2, 4'hF, 64'h8, 64'h1A);
    w_enM = 1; w_dstM = 2; w_valM = 64'hAB;
    step();
    chk("bypass d_valA", 280'(d_valA), 280'(64'hAB));
    chk("bypass d_valB", 280'(d_valB), 280'(0));
    f_valid = 0;
    w_enE = 1; w_dstE = 4; w_valE = 64'h1; w_dstM = 4; w_valM = 64'h2;
    step();
    w_enE = 0; w_enM = 0;
    fetch(1, 4'h6, 4'h0, 4'd4, 4'd4, 64'h0, 64'h20);
    step();
    chk("M wins R4", 280'(d_valA), 280'(64'h2));
    fetch(1, 4'hB, 4'h0, 4'd5, 4'hF, 64'h0, 64'h22);
    step();
    chk("popq srcs/dsts", 280'({d_srcA, d_srcB, d_dstE, d_dstM}), 280'(16'h4445));
    fetch(1, 4'h3, 4'h0, 4'hF, 4'd7, 64'h99, 64'h2C);
    step();
    chk("irmovq d_srcA", 280'(d_srcA), 280'(4'hF));
    chk("irmovq d_valA", 280'(d_valA), 280'(0));
    chk("irmovq d_dstE", 280'(d_dstE), 280'(4'd7));
    d_ready = 0;
    fetch(1, 4'h6, 4'h1, 4'd1, 4'd2, 64'h55, 64'h2E);
    w_enE = 1; w_dstE = 1; w_valE = 64'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      w_enE = 0;
      chk("hold f_ready", 280'(f_ready), 280'(0));
      chk("hold d_icode", 280'(d_icode), 280'(4'h3));
      chk("hold d_valC", 280'(d_valC), 280'(64'h99));
    end
    d_ready = 1;
    step();
    chk("release d_icode", 280'(d_icode), 280'(4'h6));
    chk("release d_valA", 280'(d_valA), 280'(64'h77));
    chk("release d_valC", 280'(d_valC), 280'(64'h55));
    for (int i = 0; i < 4; i++) begin
      fetch(1, 4'(2 + 2 * (i % 3)), 4'(i), 4'(i), 4'(i + 2), 64'(i * 3), 64'(i + 100));
      step();
    end
    chk("burst d_valP", 280'(d_valP), 280'(64'd103));
    f_valid = 0;
    step();
    chk("drain d_valid", 280'(d_valid), 280'(0));
    fetch(1, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h40);
    step();
    chk("halt stat", 280'(stat), 280'(2));
    chk("halt d_valid", 280'(d_valid), 280'(1));
    chk("halt f_ready", 280'(f_ready), 280'(0));
    fetch(1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h41);
    step(); step();
    chk("nop not taken", 280'({d_valid, d_icode, d_valP}), 280'({1'b0, 4'h0, 64'h40}));
    chk("halt sticky", 280'({f_ready, stat}), 280'({1'b0, 3'd2}));
    rst_n = 0; f_valid = 0;
    step();
    rst_n = 1;
    fetch(1, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    step();
    chk("ins stat", 280'(stat), 280'(4));
    chk("ins d_icode", 280'(d_icode), 280'(4'hC));
    d_ready = 0; f_valid = 0;
    step();
    chk("pending d_valid", 280'(d_valid), 280'(1));
    rst_n = 0;
    step();
    chk("midrst d_valid", 280'(d_valid), 280'(0));
    chk("midrst stat", 280'(stat), 280'(1));
    chk("midrst f_ready", 280'(f_ready), 280'(1));
    rst_n = 1; d_ready = 1;
    fetch(1, 4'h6, 4'h0, 4'd4, 4'd3, 64'h0, 64'h0);
    step();
    chk("zeroed R4", 280'(d_valA), 280'(0));
    chk("zeroed R3", 280'(d_valB), 280'(0));
    f_valid = 0;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
